// File: rtl/ctrl_pkg.sv
// Shared types and constants for the fetch/execute control sequencer.
package ctrl_pkg;

  localparam int CTRL_W = 14;

  // Bit positions inside the control word, MSB (loadIR) down to LSB (doJump)
  localparam int CTRL_LOAD_IR     = 13;
  localparam int CTRL_LOAD_PC     = 12;
  localparam int CTRL_LOAD_A      = 11;
  localparam int CTRL_LOAD_B      = 10;
  localparam int CTRL_LOAD_X      = 9;
  localparam int CTRL_DO_OUT      = 8;
  localparam int CTRL_STORE_MEM   = 7;
  localparam int CTRL_ASSERT_M    = 6;
  localparam int CTRL_ASSERT_E    = 5;
  localparam int CTRL_ASSERT_A    = 4;
  localparam int CTRL_ASSERT_X    = 3;
  localparam int CTRL_IMMEDIATE   = 2;
  localparam int CTRL_DO_SUBTRACT = 1;
  localparam int CTRL_DO_JUMP     = 0;

  typedef enum logic [1:0] {FETCH, EXEC, PAUSE, HALT} state_t;

  localparam logic [2:0] SRC_IMM = 3'd0;
  localparam logic [2:0] SRC_MEM = 3'd1;
  localparam logic [2:0] SRC_A   = 3'd2;
  localparam logic [2:0] SRC_X   = 3'd3;
  localparam logic [2:0] SRC_ADD = 3'd4;
  localparam logic [2:0] SRC_SUB = 3'd5;

  localparam logic [2:0] DST_A   = 3'd0;
  localparam logic [2:0] DST_B   = 3'd1;
  localparam logic [2:0] DST_X   = 3'd2;
  localparam logic [2:0] DST_OUT = 3'd3;
  localparam logic [2:0] DST_MEM = 3'd4;
  localparam logic [2:0] DST_JMP = 3'd5;
  localparam logic [2:0] DST_JZ  = 3'd6;
  localparam logic [2:0] DST_JC  = 3'd7;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational decode of sequencer state, instruction and flags into the control word.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  state_t            state,
  input  logic [7:0]        ir,
  input  logic              flag_z,
  input  logic              flag_c,
  output logic [CTRL_W-1:0] ctrl,
  output logic              pc_inc,
  output logic              is_illegal,
  output logic              uses_mem
);

  logic [2:0] src;
  logic [2:0] dst;

  assign src = ir[2:0];
  assign dst = ir[5:3];

  always_comb begin
    ctrl       = '0;
    pc_inc     = 1'b0;
    is_illegal = 1'b0;
    case (state)
      FETCH: begin
        ctrl[CTRL_LOAD_IR]   = 1'b1;
        ctrl[CTRL_ASSERT_M]  = 1'b1;
        ctrl[CTRL_IMMEDIATE] = 1'b1;
        pc_inc               = 1'b1;
      end
      EXEC: begin
        // Memory has a single port, so Mem[X] <= Mem[X] cannot be executed
        is_illegal = (ir[7:6] != 2'b00) || (src > SRC_SUB) ||
                     ((dst == DST_MEM) && (src == SRC_MEM));
        if (!is_illegal) begin
          case (src)
            SRC_IMM: begin
              ctrl[CTRL_ASSERT_M]  = 1'b1;
              ctrl[CTRL_IMMEDIATE] = 1'b1;
              pc_inc               = 1'b1;
            end
            SRC_MEM: ctrl[CTRL_ASSERT_M] = 1'b1;
            SRC_A:   ctrl[CTRL_ASSERT_A] = 1'b1;
            SRC_X:   ctrl[CTRL_ASSERT_X] = 1'b1;
            SRC_ADD: ctrl[CTRL_ASSERT_E] = 1'b1;
            SRC_SUB: begin
              ctrl[CTRL_ASSERT_E]    = 1'b1;
              ctrl[CTRL_DO_SUBTRACT] = 1'b1;
            end
            default: ;
          endcase
          case (dst)
            DST_A:   ctrl[CTRL_LOAD_A]    = 1'b1;
            DST_B:   ctrl[CTRL_LOAD_B]    = 1'b1;
            DST_X:   ctrl[CTRL_LOAD_X]    = 1'b1;
            DST_OUT: ctrl[CTRL_DO_OUT]    = 1'b1;
            DST_MEM: ctrl[CTRL_STORE_MEM] = 1'b1;
            DST_JMP: begin
              ctrl[CTRL_LOAD_PC] = 1'b1;
              ctrl[CTRL_DO_JUMP] = 1'b1;
            end
            DST_JZ: begin
              ctrl[CTRL_LOAD_PC] = flag_z;
              ctrl[CTRL_DO_JUMP] = flag_z;
            end
            DST_JC: begin
              ctrl[CTRL_LOAD_PC] = flag_c;
              ctrl[CTRL_DO_JUMP] = flag_c;
            end
          endcase
        end
      end
      default: ;
    endcase
  end

  assign uses_mem = ctrl[CTRL_ASSERT_M] | ctrl[CTRL_STORE_MEM];

endmodule

// File: rtl/control_sequencer.sv
// Fetch/execute sequencer with memory stalls, halt/pause, illegal-opcode halt and retire counter.
// Optional single-step out of PAUSE is enabled by defining SINGLE_STEP_EN.
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        ir,
  input  logic              flag_z,
  input  logic              flag_c,
  input  logic              mem_ready,
  input  logic              halt_req,
  input  logic              step,
  output logic [CTRL_W-1:0] ctrl,
  output logic              pc_inc,
  output logic              halted,
  output logic              illegal,
  output logic [CNT_W-1:0]  retired
);

  state_t state;
  logic   is_illegal;
  logic   uses_mem;
  logic   stall;
  logic   step_mode;
  logic   step_go;

  ctrl_decode u_decode (
    .state      (state),
    .ir         (ir),
    .flag_z     (flag_z),
    .flag_c     (flag_c),
    .ctrl       (ctrl),
    .pc_inc     (pc_inc),
    .is_illegal (is_illegal),
    .uses_mem   (uses_mem)
  );

  assign stall  = uses_mem & ~mem_ready;
  assign halted = (state == PAUSE) || (state == HALT);

`ifdef SINGLE_STEP_EN
  logic step_q;

  assign step_go = (state == PAUSE) && halt_req && step && !step_q;

  // step_mode carries one stepped instruction from PAUSE back to PAUSE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_q    <= 1'b0;
      step_mode <= 1'b0;
    end else begin
      step_q <= step;
      if (step_go)
        step_mode <= 1'b1;
      else if ((state == EXEC) && (is_illegal || !stall))
        step_mode <= 1'b0;
    end
  end
`else
  logic unused_step;

  assign step_mode   = 1'b0;
  assign step_go     = 1'b0;
  assign unused_step = step;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= FETCH;
      illegal <= 1'b0;
      retired <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (!stall)
            state <= (halt_req && !step_mode) ? PAUSE : EXEC;
        end
        EXEC: begin
          if (is_illegal) begin
            state   <= HALT;
            illegal <= 1'b1;
          end else if (!stall) begin
            retired <= retired + CNT_W'(1);
            state   <= step_mode ? PAUSE : FETCH;
          end
        end
        PAUSE: begin
          if (step_go || !halt_req)
            state <= FETCH;
        end
        default: state <= HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: vector table, corner sequences and a random run
// against an instruction-level reference model.
module tb_control_sequencer;

  localparam int CW = 8;

  localparam logic [13:0] LD_IR = 14'h2000, LD_PC = 14'h1000, LD_A = 14'h0800, LD_B = 14'h0400;
  localparam logic [13:0] LD_X  = 14'h0200, DOOUT = 14'h0100, ST_M = 14'h0080, AS_M = 14'h0040;
  localparam logic [13:0] AS_E  = 14'h0020, AS_A  = 14'h0010, AS_X = 14'h0008, IMM  = 14'h0004;
  localparam logic [13:0] SUB   = 14'h0002, JMP   = 14'h0001;
  localparam logic [13:0] FETCH_W = LD_IR | AS_M | IMM;

  localparam logic [13:0] SRC_T [0:5] = '{AS_M | IMM, AS_M, AS_A, AS_X, AS_E, AS_E | SUB};
  localparam logic [13:0] DST_T [0:7] = '{LD_A, LD_B, LD_X, DOOUT, ST_M, LD_PC | JMP, LD_PC | JMP, LD_PC | JMP};

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    ir;
  logic          flag_z, flag_c, mem_ready, halt_req, step;
  logic [13:0]   ctrl;
  logic          pc_inc, halted, illegal;
  logic [CW-1:0] retired;

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [CW-1:0] exp_ret;

  typedef struct {
    logic [7:0]  ir;
    logic        z;
    logic        c;
    logic [13:0] w;
    logic        pc;
  } vec_t;

  vec_t vecs [10];

  always #5 clk = ~clk;

  control_sequencer #(.CNT_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .ir        (ir),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .mem_ready (mem_ready),
    .halt_req  (halt_req),
    .step      (step),
    .ctrl      (ctrl),
    .pc_inc    (pc_inc),
    .halted    (halted),
    .illegal   (illegal),
    .retired   (retired)
  );

  // Instruction-level view of one EXEC cycle: source part OR destination part
  function automatic void model_exec(input logic [7:0] i, input logic z, input logic c,
                                     output logic [13:0] w, output logic pc, output logic bad);
    int  s = int'(i[2:0]);
    int  d = int'(i[5:3]);
    logic taken;
    bad = (i[7:6] != 2'b00) || (s > 5) || (d == 4 && s == 1);
    w   = '0;
    pc  = 1'b0;
    if (!bad) begin
      taken = (d < 6) || (d == 6 && z) || (d == 7 && c);
      w  = SRC_T[s] | (taken ? DST_T[d] : 14'h0);
      pc = (s == 0);
    end
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] i, input logic z, input logic c,
                               input logic mr, input logic hr);
    ir        = i;
    flag_z    = z;
    flag_c    = c;
    mem_ready = mr;
    halt_req  = hr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    checkOutput("reset_ctrl", 32'(ctrl), 32'(FETCH_W));
    checkOutput("reset_halted", 32'(halted), 32'd0);
    checkOutput("reset_illegal", 32'(illegal), 32'd0);
    checkOutput("reset_retired", 32'(retired), 32'd0);
    tick();
    reset   = 1'b0;
    exp_ret = '0;
  endtask

  // One instruction with memory always ready and no halt
  task automatic run_instr(input logic [7:0] i, input logic z, input logic c,
                           input logic [13:0] w, input logic pc);
    applyStimulus(i, z, c, 1'b1, 1'b0);
    checkOutput("fetch_ctrl", 32'(ctrl), 32'(FETCH_W));
    checkOutput("fetch_pc_inc", 32'(pc_inc), 32'd1);
    tick();
    applyStimulus(i, z, c, 1'b1, 1'b0);
    checkOutput("exec_ctrl", 32'(ctrl), 32'(w));
    checkOutput("exec_pc_inc", 32'(pc_inc), 32'(pc));
    tick();
    exp_ret = exp_ret + CW'(1);
    checkOutput("retired", 32'(retired), 32'(exp_ret));
  endtask

  initial begin
    logic [7:0]  ri;
    logic [13:0] w;
    logic        pc, bad, mr, z, c, stl;
    logic [7:0]  bad_ops [3];

    vecs[0] = '{8'h00, 1'b0, 1'b0, 14'h0844, 1'b1};
    vecs[1] = '{8'h24, 1'b0, 1'b0, 14'h00A0, 1'b0};
    vecs[2] = '{8'h2C, 1'b0, 1'b0, 14'h1021, 1'b0};
    vecs[3] = '{8'h32, 1'b0, 1'b0, 14'h0010, 1'b0};
    vecs[4] = '{8'h32, 1'b1, 1'b0, 14'h1011, 1'b0};
    vecs[5] = '{8'h3B, 1'b0, 1'b1, 14'h1009, 1'b0};
    vecs[6] = '{8'h3B, 1'b1, 1'b0, 14'h0008, 1'b0};
    vecs[7] = '{8'h0D, 1'b0, 1'b0, 14'h0422, 1'b0};
    vecs[8] = '{8'h11, 1'b0, 1'b0, 14'h0240, 1'b0};
    vecs[9] = '{8'h30, 1'b0, 1'b0, 14'h0044, 1'b1};
    bad_ops[0] = 8'h06;
    bad_ops[1] = 8'h80;
    bad_ops[2] = 8'h21;

    step = 1'b0;
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    do_reset();

    for (int k = 0; k < 10; k++)
      run_instr(vecs[k].ir, vecs[k].z, vecs[k].c, vecs[k].w, vecs[k].pc);

    // Store with memory not ready holds EXEC three cycles, then retires once
    applyStimulus(8'h24, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(8'h24, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("stall_ctrl", 32'(ctrl), 32'(ST_M | AS_E));
      tick();
      checkOutput("stall_retired", 32'(retired), 32'(exp_ret));
    end
    applyStimulus(8'h24, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("stall_ctrl_release", 32'(ctrl), 32'(ST_M | AS_E));
    tick();
    exp_ret = exp_ret + CW'(1);
    checkOutput("stall_retired_done", 32'(retired), 32'(exp_ret));

    // Halt request against a stalled fetch: stall wins, pause at the completing edge
    for (int k = 0; k < 2; k++) begin
      applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("haltstall_ctrl", 32'(ctrl), 32'(FETCH_W));
      checkOutput("haltstall_halted", 32'(halted), 32'd0);
      tick();
    end
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    for (int k = 0; k < 3; k++) begin
      checkOutput("pause_halted", 32'(halted), 32'd1);
      checkOutput("pause_ctrl", 32'(ctrl), 32'd0);
      checkOutput("pause_pc_inc", 32'(pc_inc), 32'd0);
      checkOutput("pause_retired", 32'(retired), 32'(exp_ret));
      tick();
    end
`ifdef SINGLE_STEP_EN
    step = 1'b1;
    tick();
    step = 1'b0;
    checkOutput("step_fetch_ctrl", 32'(ctrl), 32'(FETCH_W));
    tick();
    checkOutput("step_exec_ctrl", 32'(ctrl), 32'(LD_A | AS_M | IMM));
    tick();
    exp_ret = exp_ret + CW'(1);
    checkOutput("step_halted", 32'(halted), 32'd1);
    checkOutput("step_retired", 32'(retired), 32'(exp_ret));
`endif
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("resume_halted", 32'(halted), 32'd0);
    run_instr(8'h00, 1'b0, 1'b0, LD_A | AS_M | IMM, 1'b1);

    // Counter wrap: 255 completions reach all-ones, the next returns to zero
    do_reset();
    for (int k = 0; k < 255; k++)
      run_instr(8'h02, 1'b0, 1'b0, AS_A | LD_A, 1'b0);
    checkOutput("wrap_max", 32'(retired), 32'hFF);
    run_instr(8'h02, 1'b0, 1'b0, AS_A | LD_A, 1'b0);
    checkOutput("wrap_zero", 32'(retired), 32'd0);

    // Random legal instructions with random memory readiness and flags
    for (int k = 0; k < 200; k++) begin
      do ri = 8'($urandom_range(0, 63));
      while (ri[2:0] > 3'd5 || (ri[5:3] == 3'd4 && ri[2:0] == 3'd1));
      do begin
        mr = ($urandom_range(0, 3) != 0);
        applyStimulus(ri, 1'($urandom), 1'($urandom), mr, 1'b0);
        checkOutput("rnd_fetch_ctrl", 32'(ctrl), 32'(FETCH_W));
        tick();
      end while (!mr);
      do begin
        mr = ($urandom_range(0, 3) != 0);
        z  = 1'($urandom);
        c  = 1'($urandom);
        applyStimulus(ri, z, c, mr, 1'b0);
        model_exec(ri, z, c, w, pc, bad);
        checkOutput("rnd_exec_ctrl", 32'(ctrl), 32'(w));
        checkOutput("rnd_exec_pc_inc", 32'(pc_inc), 32'(pc));
        stl = ((w & (ST_M | AS_M)) != 14'h0) && !mr;
        tick();
      end while (stl);
      exp_ret = exp_ret + CW'(1);
      checkOutput("rnd_retired", 32'(retired), 32'(exp_ret));
    end

    // Illegal opcodes halt with a cleared control word until reset
    for (int k = 0; k < 3; k++) begin
      do_reset();
      run_instr(8'h00, 1'b0, 1'b0, LD_A | AS_M | IMM, 1'b1);
      applyStimulus(bad_ops[k], 1'b1, 1'b1, 1'b1, 1'b0);
      tick();
      applyStimulus(bad_ops[k], 1'b1, 1'b1, 1'b1, 1'b0);
      checkOutput("illegal_exec_ctrl", 32'(ctrl), 32'd0);
      checkOutput("illegal_exec_pc_inc", 32'(pc_inc), 32'd0);
      for (int j = 0; j < 3; j++) begin
        tick();
        checkOutput("halt_halted", 32'(halted), 32'd1);
        checkOutput("halt_illegal", 32'(illegal), 32'd1);
        checkOutput("halt_ctrl", 32'(ctrl), 32'd0);
        checkOutput("halt_retired", 32'(retired), 32'd1);
      end
    end
    do_reset();
    checkOutput("post_reset_illegal", 32'(illegal), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
